// File: rtl/mdio_slave_responder.sv
`timescale 1ns/1ps
// Clause 22 MDIO responder (PHY side): oversamples MDC/MDIO on the system clock,
// decodes management frames and bridges them onto a simple register port.
module mdio_slave_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        iclk_100m,
  input  logic        i_rst,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic [4:0]  o_reg_addr,
  output logic        o_reg_wr_en,
  output logic [15:0] o_reg_wr_data,
  output logic        o_reg_rd_en,
  input  logic [15:0] i_reg_rd_data,
  output logic        o_frame_err,
  output logic        o_busy
);
  localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned CNT_W = 5;
  localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_LEN);

  typedef enum logic [3:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA_W, S_TA_R, S_WDATA, S_RDATA
  } state_t;

  logic [2:0]       mdc_sync_q, mdc_sync_d;
  logic [1:0]       mdio_sync_q, mdio_sync_d;
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [14:0]      shift_q, shift_d;
  logic [15:0]      tx_q, tx_d;
  logic             is_rd_q, is_rd_d;
  logic             rd_lat_q, rd_lat_d;
  logic             mdio_q, mdio_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             rd_en_q, rd_en_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             mdc_rise, mdc_fall, bit_in;
  logic [15:0]      shift_in;

  // Pin synchronisers, MDC edge strobes and the incoming-bit shift view
  always_comb begin
    mdc_sync_d  = {mdc_sync_q[1:0], i_mdc};
    mdio_sync_d = {mdio_sync_q[0], i_mdio};
    mdc_rise    = mdc_sync_q[1] & ~mdc_sync_q[2];
    mdc_fall    = ~mdc_sync_q[1] & mdc_sync_q[2];
    bit_in      = mdio_sync_q[1];
    shift_in    = {shift_q, bit_in};
  end

  // Frame decoder: sample on MDC rise, drive on MDC fall
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    is_rd_d     = is_rd_q;
    mdio_d      = mdio_q;
    mdio_oe_d   = mdio_oe_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    frame_err_d = 1'b0;
    rd_lat_d    = rd_en_q;

    // Register bank returns data one cycle after the request
    if (rd_lat_q) tx_d = i_reg_rd_data;

    case (state_q)
      S_PRE: begin
        if (mdc_rise) begin
          if (bit_in) begin
            if (pre_cnt_q != PRE_FULL) pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end else begin
            if (pre_cnt_q == PRE_FULL) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end
      end
      S_ST: begin
        if (mdc_rise) begin
          bit_cnt_d = '0;
          state_d   = bit_in ? S_OP : S_PRE;
        end
      end
      S_OP: begin
        if (mdc_rise) begin
          shift_d   = shift_in[14:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) begin
            bit_cnt_d = '0;
            if (shift_in[1:0] == 2'b10) begin
              is_rd_d = 1'b1;
              state_d = S_PHYAD;
            end else if (shift_in[1:0] == 2'b01) begin
              is_rd_d = 1'b0;
              state_d = S_PHYAD;
            end else begin
              state_d = S_PRE;
            end
          end
        end
      end
      S_PHYAD: begin
        if (mdc_rise) begin
          shift_d   = shift_in[14:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(4)) begin
            bit_cnt_d = '0;
            state_d   = (shift_in[4:0] == PHY_ADDR) ? S_REGAD : S_PRE;
          end
        end
      end
      S_REGAD: begin
        if (mdc_rise) begin
          reg_addr_d = {reg_addr_q[3:0], bit_in};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(4)) begin
            bit_cnt_d = '0;
            if (is_rd_q) begin
              rd_en_d = 1'b1;
              state_d = S_TA_R;
            end else begin
              state_d = S_TA_W;
            end
          end
        end
      end
      S_TA_W: begin
        if (mdc_rise) begin
          shift_d   = shift_in[14:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) begin
            bit_cnt_d = '0;
            if (shift_in[1:0] == 2'b10) begin
              state_d = S_WDATA;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_PRE;
            end
          end
        end
      end
      S_TA_R: begin
        // First TA bit belongs to nobody; take the line on the fall after it
        if (bit_cnt_q == '0) begin
          if (mdc_rise) bit_cnt_d = CNT_W'(1);
        end else if (mdc_fall) begin
          mdio_oe_d = 1'b1;
          mdio_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_RDATA;
        end
      end
      S_WDATA: begin
        if (mdc_rise) begin
          shift_d   = shift_in[14:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(15)) begin
            wr_data_d = shift_in;
            wr_en_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_PRE;
          end
        end
      end
      S_RDATA: begin
        if (mdc_fall) begin
          if (bit_cnt_q == CNT_W'(16)) begin
            mdio_oe_d = 1'b0;
            mdio_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_PRE;
          end else begin
            mdio_d    = tx_q[15];
            tx_d      = {tx_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_PRE;
    endcase

    busy_d = (state_d != S_PRE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iclk_100m) begin
    if (i_rst) begin
      mdc_sync_q  <= 3'b111;
      mdio_sync_q <= 2'b11;
      state_q     <= S_PRE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      is_rd_q     <= 1'b0;
      rd_lat_q    <= 1'b0;
      mdio_q      <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      is_rd_q     <= is_rd_d;
      rd_lat_q    <= rd_lat_d;
      mdio_q      <= mdio_d;
      mdio_oe_q   <= mdio_oe_d;
      reg_addr_q  <= reg_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign o_mdio        = mdio_q;
  assign o_mdio_oe     = mdio_oe_q;
  assign o_reg_addr    = reg_addr_q;
  assign o_reg_wr_en   = wr_en_q;
  assign o_reg_wr_data = wr_data_q;
  assign o_reg_rd_en   = rd_en_q;
  assign o_frame_err   = frame_err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_mdio_slave_responder.sv
`timescale 1ns/1ps
// Bench for mdio_slave_responder: an MDIO master drives frames at 5 MHz, a small
// register bank answers reads, and a frame-level model predicts every outcome.
module tb_mdio_slave_responder;
  localparam logic [4:0] PHY = 5'd1;

  logic        clk, rst, mdc, mdio_pad;
  logic        o_mdio, o_oe, wr_en, rd_en, ferr, busy;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data, rd_data;
  logic        m_oe, m_drv;
  logic        seed_en;
  logic [4:0]  seed_addr;
  logic [15:0] seed_val;
  logic [15:0] bank [32];
  logic [15:0] model_mem [32];

  int total = 0;
  int bad   = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_busy = 0, n_ovl = 0;
  logic [4:0]  wr_addr_seen, rd_addr_seen;
  logic [15:0] wr_data_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Open-drain style pad with pull-up: DUT drive wins, else master, else 1
  assign mdio_pad = o_oe ? o_mdio : (m_oe ? m_drv : 1'b1);

  mdio_slave_responder #(.PHY_ADDR(PHY), .PREAMBLE_LEN(32)) dut (
    .iclk_100m    (clk),
    .i_rst        (rst),
    .i_mdc        (mdc),
    .i_mdio       (mdio_pad),
    .o_mdio       (o_mdio),
    .o_mdio_oe    (o_oe),
    .o_reg_addr   (reg_addr),
    .o_reg_wr_en  (wr_en),
    .o_reg_wr_data(wr_data),
    .o_reg_rd_en  (rd_en),
    .i_reg_rd_data(rd_data),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  // Register bank: read data valid only on the cycle after the request
  always @(posedge clk) begin
    if (seed_en) bank[seed_addr] <= seed_val;
    else if (wr_en) bank[reg_addr] <= wr_data;
    rd_data <= rd_en ? bank[reg_addr] : 16'($urandom);
  end

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin n_wr++; wr_addr_seen = reg_addr; wr_data_seen = wr_data; end
      if (rd_en) begin n_rd++; rd_addr_seen = reg_addr; end
      if (ferr) n_err++;
      if (o_oe) n_oe++;
      if (busy) n_busy++;
      if ((int'(wr_en) + int'(rd_en) + int'(ferr)) > 1) n_ovl++;
    end
  end

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic seed(input logic [4:0] a, input logic [15:0] v);
    seed_addr = a; seed_val = v; seed_en = 1'b1;
    @(posedge clk); #1;
    seed_en = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #3;
    m_oe = 1'b1; m_drv = b;
    #100 mdc = 1'b1;
    #100 mdc = 0;
    m_oe = 1'b0;
  endtask

  // Master side of one frame; reads release the line after REGAD and sample
  // TA bit 2 plus 16 data bits. Stops with MDC high at bit index stop_j.
  task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data,
                            input bit rel, input int stop_j,
                            output logic [16:0] rbits, output int oe_rises);
    bit q[$];
    int hdr;
    rbits = '0;
    oe_rises = 0;
    for (int i = 0; i < pre_len; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 1; i >= 0; i--) q.push_back(op[i]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    hdr = q.size();
    for (int i = 1; i >= 0; i--) q.push_back(ta[i]);
    for (int i = 15; i >= 0; i--) q.push_back(data[i]);
    @(posedge clk); #3;
    for (int j = 0; j < q.size(); j++) begin
      m_oe  = !(rel && j >= hdr);
      m_drv = q[j];
      #100;
      if (rel && j >= hdr + 1) rbits = {rbits[15:0], mdio_pad};
      if (o_oe) oe_rises++;
      mdc = 1'b1;
      if (j == stop_j) return;
      #100;
      mdc = 1'b0;
    end
    m_oe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mdc = 1'b0; m_oe = 1'b0; m_drv = 1'b1; seed_en = 1'b0;
    seed_addr = '0; seed_val = '0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (o_mdio !== 1'b1) begin bad++; $display("FAIL rst_mdio got=%0b want=1", o_mdio); end
    total++; if (o_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%0b want=0", o_oe); end
    total++; if (reg_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0h want=0", reg_addr); end
    total++; if (wr_data !== 16'd0) begin bad++; $display("FAIL rst_wdata got=%0h want=0", wr_data); end
    total++; if ({wr_en, rd_en, ferr, busy} !== 4'b0) begin
      bad++; $display("FAIL rst_strobes got=%b want=0000", {wr_en, rd_en, ferr, busy});
    end
    rst = 1'b0;
    settle();
    for (int i = 0; i < 32; i++) seed(5'(i), 16'($urandom));
  endtask

  task automatic test_write();
    logic [16:0] rb; int oer;
    int b_wr = n_wr, b_rd = n_rd, b_err = n_err, b_oe = n_oe, b_busy = n_busy;
    send_frame(32, 2'b01, PHY, 5'd5, 2'b10, 16'hA55A, 1'b0, -1, rb, oer);
    settle();
    model_mem[5] = 16'hA55A;
    total++; if (n_wr - b_wr != 1) begin bad++; $display("FAIL wr_count got=%0d want=1", n_wr - b_wr); end
    total++; if (wr_addr_seen !== 5'd5) begin bad++; $display("FAIL wr_addr got=%0h want=5", wr_addr_seen); end
    total++; if (wr_data_seen !== 16'hA55A) begin bad++; $display("FAIL wr_data got=%0h want=a55a", wr_data_seen); end
    total++; if (n_oe - b_oe != 0) begin bad++; $display("FAIL wr_oe got=%0d want=0", n_oe - b_oe); end
    total++; if ((n_rd - b_rd) + (n_err - b_err) != 0) begin
      bad++; $display("FAIL wr_other_strobes got=%0d want=0", (n_rd - b_rd) + (n_err - b_err));
    end
    total++; if (n_busy - b_busy != 620) begin bad++; $display("FAIL wr_busy got=%0d want=620", n_busy - b_busy); end
  endtask

  task automatic test_read();
    logic [16:0] rb; int oer;
    int b_wr, b_rd, b_oe, b_busy;
    seed(5'd2, 16'h1234);
    b_wr = n_wr; b_rd = n_rd; b_oe = n_oe; b_busy = n_busy;
    send_frame(32, 2'b10, PHY, 5'd2, 2'b00, 16'h0, 1'b1, -1, rb, oer);
    settle();
    total++; if (n_rd - b_rd != 1) begin bad++; $display("FAIL rd_count got=%0d want=1", n_rd - b_rd); end
    total++; if (rd_addr_seen !== 5'd2) begin bad++; $display("FAIL rd_addr got=%0h want=2", rd_addr_seen); end
    total++; if (rb !== {1'b0, 16'h1234}) begin bad++; $display("FAIL rd_bits got=%05h want=%05h", rb, {1'b0, 16'h1234}); end
    total++; if (oer != 17) begin bad++; $display("FAIL rd_oe_periods got=%0d want=17", oer); end
    total++; if (n_oe - b_oe != 340) begin bad++; $display("FAIL rd_oe_cycles got=%0d want=340", n_oe - b_oe); end
    total++; if (n_busy - b_busy != 630) begin bad++; $display("FAIL rd_busy got=%0d want=630", n_busy - b_busy); end
    total++; if (n_wr - b_wr != 0) begin bad++; $display("FAIL rd_wr_strobe got=%0d want=0", n_wr - b_wr); end
  endtask

  task automatic test_phyad_mismatch();
    logic [16:0] rb; int oer;
    int b_wr = n_wr, b_rd = n_rd, b_err = n_err, b_oe = n_oe, b_busy = n_busy;
    send_frame(32, 2'b10, 5'd3, 5'd2, 2'b00, 16'h0, 1'b1, -1, rb, oer);
    settle();
    total++; if ((n_wr - b_wr) + (n_rd - b_rd) + (n_err - b_err) != 0) begin
      bad++; $display("FAIL mis_strobes got=%0d want=0", (n_wr - b_wr) + (n_rd - b_rd) + (n_err - b_err));
    end
    total++; if (n_oe - b_oe != 0) begin bad++; $display("FAIL mis_oe got=%0d want=0", n_oe - b_oe); end
    total++; if (n_busy - b_busy != 160) begin bad++; $display("FAIL mis_busy got=%0d want=160", n_busy - b_busy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_busy_end got=%0b want=0", busy); end
  endtask

  task automatic test_short_preamble();
    logic [16:0] rb; int oer;
    int b_wr, b_busy;
    send_bit(1'b0);
    b_wr = n_wr; b_busy = n_busy;
    send_frame(31, 2'b01, PHY, 5'd9, 2'b10, 16'hA55A, 1'b0, -1, rb, oer);
    settle();
    total++; if (n_wr - b_wr != 0) begin bad++; $display("FAIL short_wr got=%0d want=0", n_wr - b_wr); end
    total++; if (n_busy - b_busy != 0) begin bad++; $display("FAIL short_busy got=%0d want=0", n_busy - b_busy); end
    b_wr = n_wr;
    send_frame(32, 2'b01, PHY, 5'd9, 2'b10, 16'h0F0F, 1'b0, -1, rb, oer);
    settle();
    model_mem[9] = 16'h0F0F;
    total++; if (n_wr - b_wr != 1) begin bad++; $display("FAIL full_wr got=%0d want=1", n_wr - b_wr); end
    total++; if ({wr_addr_seen, wr_data_seen} !== {5'd9, 16'h0F0F}) begin
      bad++; $display("FAIL full_wr_payload got=%0h/%0h want=9/f0f", wr_addr_seen, wr_data_seen);
    end
  endtask

  task automatic test_bad_ta();
    logic [16:0] rb; int oer;
    int b_wr = n_wr, b_err = n_err, b_busy = n_busy;
    send_frame(32, 2'b01, PHY, 5'd7, 2'b11, 16'h5555, 1'b0, -1, rb, oer);
    settle();
    total++; if (n_err - b_err != 1) begin bad++; $display("FAIL ta_err got=%0d want=1", n_err - b_err); end
    total++; if (n_wr - b_wr != 0) begin bad++; $display("FAIL ta_wr got=%0d want=0", n_wr - b_wr); end
    total++; if (n_busy - b_busy != 300) begin bad++; $display("FAIL ta_busy got=%0d want=300", n_busy - b_busy); end
    b_wr = n_wr; b_err = n_err;
    send_frame(32, 2'b01, PHY, 5'd7, 2'b10, 16'hC3C3, 1'b0, -1, rb, oer);
    settle();
    model_mem[7] = 16'hC3C3;
    total++; if ((n_wr - b_wr != 1) || (wr_data_seen !== 16'hC3C3) || (n_err != b_err)) begin
      bad++; $display("FAIL ta_recover got=%0d/%0h/%0d want=1/c3c3/0", n_wr - b_wr, wr_data_seen, n_err - b_err);
    end
  endtask

  task automatic test_random();
    logic [1:0] op, ta; logic [4:0] phy, ra; logic [15:0] data;
    logic [16:0] rb; int oer, r, exp_busy, exp_oe;
    int b_wr, b_rd, b_err, b_oe, b_busy;
    bit op_ok, hit, rd_ok, wr_ok, err_ok;
    for (int k = 0; k < 10; k++) begin
      r    = int'($urandom_range(0, 9));
      op   = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : ((r == 8) ? 2'b00 : 2'b11);
      phy  = ($urandom_range(0, 1) == 1) ? PHY : 5'($urandom);
      ra   = 5'($urandom);
      data = 16'($urandom);
      ta   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      op_ok  = (op == 2'b01) || (op == 2'b10);
      hit    = op_ok && (phy == PHY);
      rd_ok  = hit && (op == 2'b10);
      wr_ok  = hit && (op == 2'b01) && (ta == 2'b10);
      err_ok = hit && (op == 2'b01) && (ta != 2'b10);
      if (!op_ok) exp_busy = 60;
      else if (phy != PHY) exp_busy = 160;
      else if (op == 2'b10) exp_busy = 630;
      else if (ta != 2'b10) exp_busy = 300;
      else exp_busy = 620;
      exp_oe = rd_ok ? 340 : 0;
      b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_oe = n_oe; b_busy = n_busy;
      send_frame(32, op, phy, ra, ta, data, (op == 2'b10), -1, rb, oer);
      settle();
      total++; if (n_wr - b_wr != int'(wr_ok)) begin bad++; $display("FAIL rnd%0d_wr got=%0d want=%0d", k, n_wr - b_wr, wr_ok); end
      total++; if (n_rd - b_rd != int'(rd_ok)) begin bad++; $display("FAIL rnd%0d_rd got=%0d want=%0d", k, n_rd - b_rd, rd_ok); end
      total++; if (n_err - b_err != int'(err_ok)) begin bad++; $display("FAIL rnd%0d_err got=%0d want=%0d", k, n_err - b_err, err_ok); end
      total++; if (n_oe - b_oe != exp_oe) begin bad++; $display("FAIL rnd%0d_oe got=%0d want=%0d", k, n_oe - b_oe, exp_oe); end
      total++; if (n_busy - b_busy != exp_busy) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", k, n_busy - b_busy, exp_busy); end
      if (wr_ok) begin
        total++; if ({wr_addr_seen, wr_data_seen} !== {ra, data}) begin
          bad++; $display("FAIL rnd%0d_wpay got=%0h/%0h want=%0h/%0h", k, wr_addr_seen, wr_data_seen, ra, data);
        end
        model_mem[ra] = data;
      end
      if (rd_ok) begin
        total++; if (rb !== {1'b0, model_mem[ra]}) begin
          bad++; $display("FAIL rnd%0d_rbits got=%05h want=%05h", k, rb, {1'b0, model_mem[ra]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [16:0] rb; int oer;
    int b_wr, b_rd;
    seed(5'd12, 16'hBEEF);
    send_frame(32, 2'b10, PHY, 5'd12, 2'b00, 16'h0, 1'b1, 56, rb, oer);
    #40;
    total++; if (o_oe !== 1'b1) begin bad++; $display("FAIL mid_oe_before got=%0b want=1", o_oe); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (o_oe !== 1'b0) begin bad++; $display("FAIL mid_oe_after got=%0b want=0", o_oe); end
    total++; if ({o_mdio, reg_addr, wr_data, wr_en, rd_en, ferr, busy} !== {1'b1, 5'd0, 16'd0, 4'b0}) begin
      bad++; $display("FAIL mid_reset_vals got=%0b/%0h/%0h/%b want=1/0/0/0000",
                      o_mdio, reg_addr, wr_data, {wr_en, rd_en, ferr, busy});
    end
    rst = 1'b0;
    b_wr = n_wr; b_rd = n_rd;
    #60 mdc = 1'b0;
    m_oe = 1'b0;
    settle();
    total++; if ((n_wr - b_wr) + (n_rd - b_rd) != 0) begin
      bad++; $display("FAIL mid_pending got=%0d want=0", (n_wr - b_wr) + (n_rd - b_rd));
    end
    send_frame(32, 2'b10, PHY, 5'd12, 2'b00, 16'h0, 1'b1, -1, rb, oer);
    settle();
    total++; if (rb !== {1'b0, 16'hBEEF}) begin bad++; $display("FAIL mid_reread got=%05h want=%05h", rb, {1'b0, 16'hBEEF}); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] rb1, rb2, rb3; int oer;
    int b_wr, b_rd, b_busy;
    seed(5'd20, 16'h8001);
    seed(5'd21, 16'h7FFE);
    b_wr = n_wr; b_rd = n_rd; b_busy = n_busy;
    send_frame(32, 2'b10, PHY, 5'd20, 2'b00, 16'h0, 1'b1, -1, rb1, oer);
    send_frame(32, 2'b10, PHY, 5'd21, 2'b00, 16'h0, 1'b1, -1, rb2, oer);
    send_frame(31, 2'b01, PHY, 5'd22, 2'b10, 16'h1111, 1'b0, -1, rb3, oer);
    settle();
    total++; if ({rb1, rb2} !== {1'b0, 16'h8001, 1'b0, 16'h7FFE}) begin
      bad++; $display("FAIL b2b_bits got=%05h/%05h want=08001/07ffe", rb1, rb2);
    end
    total++; if (n_rd - b_rd != 2) begin bad++; $display("FAIL b2b_rd got=%0d want=2", n_rd - b_rd); end
    total++; if (n_wr - b_wr != 0) begin bad++; $display("FAIL b2b_short_wr got=%0d want=0", n_wr - b_wr); end
    total++; if (n_busy - b_busy != 1260) begin bad++; $display("FAIL b2b_busy got=%0d want=1260", n_busy - b_busy); end
    total++; if (n_ovl != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", n_ovl); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phyad_mismatch();
    test_short_preamble();
    test_bad_ta();
    test_random();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_slave_responder.md
# mdio_slave_responder

MDIO management-frame responder (Clause 22, PHY side) clocked from the 100 MHz system clock. It oversamples the MDC/MDIO pins from a 5 MHz MDC master and decodes preamble, ST, OP, PHYAD, REGAD and TA. On a write frame it issues a register-write strobe. On a read frame it fetches register data and drives TA and DATA back onto MDIO. The block sits behind the MDIO pad as the target for the team's MDIO master, exposing a simple register port to a PHY or emulated register bank.

## Interface
- PHY_ADDR, 5'd1, PHYAD this responder answers to
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST
- iclk_100m  input  1  system clock, 100 MHz
- i_rst  input  1  reset, synchronous, active-high
- i_mdc  input  1  MDC pin, asynchronous to iclk_100m, at most 5 MHz
- i_mdio  input  1  MDIO pin input value
- o_mdio  output  1  MDIO drive value
- o_mdio_oe  output  1  MDIO output enable; pad tri-states when 0
- o_reg_addr  output  5  REGAD of the current frame
- o_reg_wr_en  output  1  one-cycle write strobe
- o_reg_wr_data  output  16  write data, valid with o_reg_wr_en
- o_reg_rd_en  output  1  one-cycle read request
- i_reg_rd_data  input  16  read data, valid exactly 1 cycle after o_reg_rd_en
- o_frame_err  output  1  one-cycle pulse on malformed frame addressed to PHY_ADDR
- o_busy  output  1  high from ST detection until frame end or abort

## Operation
- **Synchronisers.** i_mdc and i_mdio each pass through a 2-FF synchroniser. MDC rise and fall strobes come from the synchronised MDC and its 1-cycle delayed copy.
- **Sampling and driving.** Incoming bits are sampled on the MDC rise strobe. Outgoing bits update on the MDC fall strobe.
- **States:**
  - PRE: count sampled 1s, saturating at PREAMBLE_LEN. A 0 with count < PREAMBLE_LEN clears the count. A 0 with count = PREAMBLE_LEN is ST bit 0 and moves to ST.
  - ST: expects 1. On a 0, return to PRE with count 0 and no o_frame_err (PHYAD is not yet known).
  - OP: 2 bits, MSB first. 10 = read, 01 = write. Any other value returns to PRE silently.
  - PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR, return to PRE with count 0. No drive and no strobes occur for that frame.
  - REGAD: 5 bits, MSB first, shifted into o_reg_addr. For a read, o_reg_rd_en pulses on the cycle after the last REGAD bit is sampled. i_reg_rd_data is latched into the 16-bit TX shift register on the following cycle.
  - TA_W (write): the 2 sampled bits must be 1 then 0. Otherwise pulse o_frame_err and return to PRE.
  - TA_R (read): the 1st TA bit is not driven. On the first fall strobe after it, assert o_mdio_oe with o_mdio = 0.
  - WDATA: 16 bits, MSB first. On the cycle after the 16th bit is sampled, o_reg_wr_en pulses for 1 cycle with o_reg_wr_data and o_reg_addr stable. Then return to PRE.
  - RDATA: on each of the next 16 fall strobes, drive TX bits [15] down to [0]. On the 17th fall strobe after TA, deassert o_mdio_oe, drop o_mdio to 1, and return to PRE.
- **Preamble counter in frame.** The counter resets to 0 on every return to PRE. It is not incremented during a frame, so data 1s never count toward the preamble.
- **Register latches.** o_reg_addr and o_reg_wr_data hold their last values between frames.

## Timing
- **Reset values:** o_mdio = 1, o_mdio_oe = 0, o_reg_addr = 0, o_reg_wr_en = 0, o_reg_wr_data = 0, o_reg_rd_en = 0, o_frame_err = 0, o_busy = 0. State is PRE with count 0.
- **Strobe latency.** An MDC edge at the pin produces its strobe 3 iclk_100m cycles later (2 synchroniser stages plus edge detect).
- **Drive latency.** o_mdio changes 4 cycles after the MDC falling edge at the pin, i.e. 40 ns, well inside the 100 ns half period.
- **Register-read deadline.** o_reg_rd_en to TX latch takes 2 cycles. This completes long before the TA fall strobe, at least 20 cycles later.
- **Strobes.** o_reg_wr_en, o_reg_rd_en and o_frame_err are single-cycle and never overlap.
- **Reset mid-frame.** Reset wins over everything. o_mdio_oe is 0 on the cycle after i_rst is sampled. No pending strobe fires. The next frame must present a full preamble.
- **MDC stopped mid-frame.** The FSM holds its state indefinitely; there is no timeout.
- **Edge coincidence.** Rise and fall strobes can never coincide.
- **Back-to-back frames.** A frame starting immediately after RDATA ends needs a full PREAMBLE_LEN preamble.

## Test plan
- **Write frame.** 32×1, 01, 01, PHYAD 00001, REGAD 00101, TA 10, data 0xA55A -> exactly one o_reg_wr_en with o_reg_addr = 5 and o_reg_wr_data = 0xA55A; o_mdio_oe stays 0 throughout.
- **Read frame.** Read of REGAD 00010 with i_reg_rd_data = 0x1234 -> one o_reg_rd_en; o_mdio_oe high for exactly 17 MDC periods; bits sampled at MDC rise are 0, then 0001 0010 0011 0100.
- **PHYAD mismatch.** Read frame to PHYAD 00011 -> no strobes, o_mdio_oe never asserted, o_busy drops after the PHYAD bits.
- **Short preamble.** 31×1 followed by a valid write frame -> ignored, no strobes. A following frame with 32×1 is accepted.
- **Bad TA.** Write frame with TA = 11 -> o_frame_err pulses once, no o_reg_wr_en. The next valid frame is processed normally.
- **Reset mid-read.** i_rst asserted during RDATA bit 7 -> o_mdio_oe = 0 the next cycle, all outputs at reset values. A subsequent read returns the correct data.
